udp_tx_framer: RTL
==================

// Module: udp_tx_framer
// PURPOSE
//  UDP transmit framer between the user UDP TX interface and the IPv4 TX stage.
//  Latches a UDP TX header on start, then requests an IPv4 TX with protocol 0x11 and length data_length+8.
//  Emits the 8-byte UDP header, then passes the user payload bytes through to IPv4 TX.
//  Reports progress using the UDPTX_RESULT_* codes (NONE=0, SENDING=1, ERR=2, SENT=3).
// PARAMETERS
//  MAX_PAYLOAD   65507   largest accepted data_length in bytes; 0 or >MAX_PAYLOAD -> ERR
//  UDP_PROTOCOL  8'h11   value driven on ip_tx_protocol
// PORTS
//  clk                  in   1   single clock, rising edge
//  rst_n                in   1   asynchronous active-low reset
//  udp_tx_start         in   1   start request; sampled in IDLE only
//  udp_tx_dst_ip_addr   in   32  destination IP
//  udp_tx_dst_port      in   16  destination port
//  udp_tx_src_port      in   16  source port
//  udp_tx_data_length   in   16  payload bytes (UDP header excluded)
//  udp_tx_checksum      in   16  checksum field, passed verbatim (0 = none)
//  udp_tx_data_valid    in   1   user payload byte valid
//  udp_tx_data_last     in   1   user payload last byte
//  udp_tx_data          in   8   user payload byte
//  udp_tx_data_ready    out  1   user payload byte accepted when valid&ready
//  udp_tx_result        out  2   UDPTX_RESULT_* code
//  ip_tx_start          out  1   IPv4 TX request
//  ip_tx_protocol       out  8   = UDP_PROTOCOL
//  ip_tx_data_length    out  16  latched data_length + 8
//  ip_tx_dst_ip_addr    out  32  latched dst IP
//  ip_tx_result         in   2   IPTX_RESULT_* code from IPv4 TX
//  ip_tx_data_ready     in   1   IPv4 TX accepts a byte
//  ip_tx_data_valid     out  1   byte valid to IPv4 TX
//  ip_tx_data_last      out  1   last byte to IPv4 TX
//  ip_tx_data           out  8   byte to IPv4 TX
// BEHAVIOUR
//  Reset (async, immediate, also mid-frame): state IDLE; all outputs 0; result NONE; byte counters 0.
//  FSM: IDLE -> REQ -> HDR -> PAYLOAD -> IDLE; FLUSH only with the length-check option.
//  IDLE
//   - udp_tx_data_ready = 0.
//   - On udp_tx_start: latch all header fields; result <= SENDING.
//   - Length 0 or >MAX_PAYLOAD: result <= ERR, stay IDLE, no ip_tx_start.
//   - Otherwise go to REQ.
//  REQ
//   - ip_tx_start held 1.
//   - ip_tx_result==SENDING -> HDR, start deasserted.
//   - ip_tx_result==ERR -> result ERR, IDLE.
//  HDR
//   - 3-bit counter 0..7 sends src_port[15:8], src_port[7:0], dst_port hi/lo, (len+8) hi/lo, checksum hi/lo.
//   - ip_tx_data_valid = 1; counter advances only when ip_tx_data_ready=1.
//   - Byte 7 accepted -> PAYLOAD. ip_tx_data_last = 0 throughout HDR.
//  PAYLOAD (combinational pass-through, zero latency)
//   - ip_tx_data/valid/last = user data/valid/last.
//   - udp_tx_data_ready = ip_tx_data_ready.
//   - Transfer with last -> result SENT, IDLE.
//  Results are sticky: held until the next accepted start.
//  udp_tx_start while not IDLE: ignored, no effect on the frame in flight.
//  A user byte presented before PAYLOAD is not consumed (ready=0).
//  ip_tx_result==ERR in HDR or PAYLOAD: result ERR, IDLE, remaining user bytes not consumed.
//  Header fields change after start: no effect (latched copy used).
// CONFIGURATION
//  UDP_TX_LEN_CHECK_EN defined:
//   - 16-bit payload counter compared against latched data_length.
//   - User last on byte n<data_length -> forwarded as ip last; result ERR; IDLE.
//   - Byte n==data_length without user last -> ip_tx_data_last forced 1, result ERR, FLUSH.
//   - FLUSH: udp_tx_data_ready=1, ip_tx_data_valid=0; user bytes dropped until user last; then IDLE.
//  UDP_TX_LEN_CHECK_EN undefined:
//   - No counter, no FLUSH state; frame end is the user last only; result SENT.
// TESTING
//  1. len=4, ports 0x1234->0x5678, cksum 0, ip SENDING after 2 clk, ready=1: header 12 34 56 78 00 0C 00 00 then 4 bytes; result SENDING->SENT.
//  2. Same frame, ip_tx_data_ready toggling 1/0 every clk: all 12 bytes in order, none duplicated or lost.
//  3. len=0 start -> result ERR next clk, ip_tx_start never asserted; len=65508 -> same.
//  4. ip_tx_result=ERR while in REQ -> result ERR, IDLE, udp_tx_data_ready stays 0.
//  5. With _EN, len=4, user last on byte 2 -> ip last on byte 2, ERR; len=2, user sends 5 -> ip last on byte 2, 3 bytes flushed, ERR.
//  6. rst_n low mid-PAYLOAD -> outputs 0 and result NONE without a clk edge; a new len=1 frame then completes SENT.

Source files
------------

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: UDP transmit framer between the user UDP TX interface and the
// IPv4 TX stage. It latches the UDP header on start, requests an IPv4 transmit
// (protocol UDP_PROTOCOL, length data_length+8), emits the 8-byte UDP header,
// then passes user payload bytes straight through to the IPv4 TX stage.
//
// Optional feature: define UDP_TX_LEN_CHECK_EN to count payload bytes against
// the latched data_length. A short frame ends with ERR. A long frame is
// truncated with a forced ip last, and the excess user bytes are dropped in
// FLUSH.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   udp_tx_start            start request (sampled in IDLE only)
//   udp_tx_dst_ip_addr      destination IP address
//   udp_tx_dst_port         destination port
//   udp_tx_src_port         source port
//   udp_tx_data_length      payload length in bytes, UDP header excluded
//   udp_tx_checksum         checksum field, passed verbatim
//   udp_tx_data_*           user payload stream (valid/last/data in, ready out)
//   udp_tx_result           NONE=0 SENDING=1 ERR=2 SENT=3 (sticky)
//   ip_tx_start             IPv4 TX request
//   ip_tx_protocol          latched protocol number
//   ip_tx_data_length       latched data_length + 8
//   ip_tx_dst_ip_addr       latched destination IP address
//   ip_tx_result            IPv4 TX status, using the same code set
//   ip_tx_data_*            byte stream to IPv4 TX (ready in, valid/last/data out)
module udp_tx_framer #(
   parameter int unsigned MAX_PAYLOAD  = 65507,
   parameter logic [7:0]  UDP_PROTOCOL = 8'h11
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        udp_tx_start,
   input  logic [31:0] udp_tx_dst_ip_addr,
   input  logic [15:0] udp_tx_dst_port,
   input  logic [15:0] udp_tx_src_port,
   input  logic [15:0] udp_tx_data_length,
   input  logic [15:0] udp_tx_checksum,
   input  logic        udp_tx_data_valid,
   input  logic        udp_tx_data_last,
   input  logic [7:0]  udp_tx_data,
   output logic        udp_tx_data_ready,
   output logic [1:0]  udp_tx_result,
   output logic        ip_tx_start,
   output logic [7:0]  ip_tx_protocol,
   output logic [15:0] ip_tx_data_length,
   output logic [31:0] ip_tx_dst_ip_addr,
   input  logic [1:0]  ip_tx_result,
   input  logic        ip_tx_data_ready,
   output logic        ip_tx_data_valid,
   output logic        ip_tx_data_last,
   output logic [7:0]  ip_tx_data
);

   localparam int unsigned LEN_W   = 16;
   localparam int unsigned HCNT_W  = 3;
   localparam logic [1:0]  RES_NONE    = 2'd0;
   localparam logic [1:0]  RES_SENDING = 2'd1;
   localparam logic [1:0]  RES_ERR     = 2'd2;
   localparam logic [1:0]  RES_SENT    = 2'd3;
   localparam logic [LEN_W-1:0] UDP_HDR_LEN = LEN_W'(8);

`ifdef UDP_TX_LEN_CHECK_EN
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_HDR, S_PAYLOAD, S_FLUSH} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_HDR, S_PAYLOAD} state_t;
`endif

   state_t             state_q, state_d;
   logic [1:0]         result_q, result_d;
   logic [15:0]        src_port_q, dst_port_q, cksum_q, ip_len_q;
   logic [31:0]        dst_ip_q;
   logic [7:0]         proto_q;
   logic [HCNT_W-1:0]  hdr_cnt_q;
   logic               start_c;
   logic               len_bad_c;
   logic               pay_xfer_c;
   logic               ip_err_c;
   logic               pay_end_c;
   logic [7:0]         hdr_byte_c;
`ifdef UDP_TX_LEN_CHECK_EN
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   pay_cnt_q;
`endif

   assign start_c    = (state_q == S_IDLE) && udp_tx_start;
   assign len_bad_c  = (udp_tx_data_length == '0) ||
                       (32'(udp_tx_data_length) > MAX_PAYLOAD);
   assign ip_err_c   = (ip_tx_result == RES_ERR);
   assign pay_xfer_c = (state_q == S_PAYLOAD) && udp_tx_data_valid && udp_tx_data_ready;

   // Current payload byte is the last one the latched length allows
`ifdef UDP_TX_LEN_CHECK_EN
   assign pay_end_c  = ((pay_cnt_q + LEN_W'(1)) == len_q);
`else
   assign pay_end_c  = 1'b0;
`endif

   // Header byte select: src port, dst port, udp length, checksum (MSB first)
   always_comb begin
      hdr_byte_c = 8'h00;
      case (hdr_cnt_q)
         3'd0: hdr_byte_c = src_port_q[15:8];
         3'd1: hdr_byte_c = src_port_q[7:0];
         3'd2: hdr_byte_c = dst_port_q[15:8];
         3'd3: hdr_byte_c = dst_port_q[7:0];
         3'd4: hdr_byte_c = ip_len_q[15:8];
         3'd5: hdr_byte_c = ip_len_q[7:0];
         3'd6: hdr_byte_c = cksum_q[15:8];
         3'd7: hdr_byte_c = cksum_q[7:0];
         default: hdr_byte_c = 8'h00;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and next-result logic
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (udp_tx_start) begin
               if (len_bad_c) begin
                  result_d = RES_ERR;
               end else begin
                  result_d = RES_SENDING;
                  state_d  = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (ip_tx_result == RES_SENDING) begin
               state_d = S_HDR;
            end else if (ip_err_c) begin
               result_d = RES_ERR;
               state_d  = S_IDLE;
            end
         end
         S_HDR: begin
            if (ip_err_c) begin
               result_d = RES_ERR;
               state_d  = S_IDLE;
            end else if (ip_tx_data_ready && (hdr_cnt_q == HCNT_W'(7))) begin
               state_d = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (ip_err_c) begin
               result_d = RES_ERR;
               state_d  = S_IDLE;
            end else if (pay_xfer_c) begin
`ifdef UDP_TX_LEN_CHECK_EN
               if (udp_tx_data_last) begin
                  result_d = pay_end_c ? RES_SENT : RES_ERR;
                  state_d  = S_IDLE;
               end else if (pay_end_c) begin
                  result_d = RES_ERR;
                  state_d  = S_FLUSH;
               end
`else
               if (udp_tx_data_last) begin
                  result_d = RES_SENT;
                  state_d  = S_IDLE;
               end
`endif
            end
         end
`ifdef UDP_TX_LEN_CHECK_EN
         S_FLUSH: begin
            if (udp_tx_data_valid && udp_tx_data_last) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode; payload is a zero-latency pass-through
   always_comb begin
      udp_tx_data_ready = 1'b0;
      ip_tx_start       = 1'b0;
      ip_tx_data_valid  = 1'b0;
      ip_tx_data_last   = 1'b0;
      ip_tx_data        = 8'h00;
      case (state_q)
         S_REQ: ip_tx_start = 1'b1;
         S_HDR: begin
            ip_tx_data_valid = 1'b1;
            ip_tx_data       = hdr_byte_c;
         end
         S_PAYLOAD: begin
            ip_tx_data_valid  = udp_tx_data_valid;
            ip_tx_data_last   = udp_tx_data_last | pay_end_c;
            ip_tx_data        = udp_tx_data;
            // A byte offered while IPv4 TX reports an error is not consumed
            udp_tx_data_ready = ip_tx_data_ready && !ip_err_c;
         end
`ifdef UDP_TX_LEN_CHECK_EN
         S_FLUSH: udp_tx_data_ready = 1'b1;
`endif
         default: ;
      endcase
   end

   // Result, latched header fields and byte counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q   <= RES_NONE;
         src_port_q <= '0;
         dst_port_q <= '0;
         cksum_q    <= '0;
         ip_len_q   <= '0;
         dst_ip_q   <= '0;
         proto_q    <= '0;
         hdr_cnt_q  <= '0;
`ifdef UDP_TX_LEN_CHECK_EN
         len_q      <= '0;
         pay_cnt_q  <= '0;
`endif
      end else begin
         result_q <= result_d;
         if (start_c) begin
            src_port_q <= udp_tx_src_port;
            dst_port_q <= udp_tx_dst_port;
            cksum_q    <= udp_tx_checksum;
            ip_len_q   <= udp_tx_data_length + UDP_HDR_LEN;
            dst_ip_q   <= udp_tx_dst_ip_addr;
            proto_q    <= UDP_PROTOCOL;
            hdr_cnt_q  <= '0;
`ifdef UDP_TX_LEN_CHECK_EN
            len_q      <= udp_tx_data_length;
            pay_cnt_q  <= '0;
`endif
         end else begin
            if ((state_q == S_HDR) && ip_tx_data_ready) hdr_cnt_q <= hdr_cnt_q + HCNT_W'(1);
`ifdef UDP_TX_LEN_CHECK_EN
            if (pay_xfer_c) pay_cnt_q <= pay_cnt_q + LEN_W'(1);
`endif
         end
      end
   end

   assign udp_tx_result     = result_q;
   assign ip_tx_protocol    = proto_q;
   assign ip_tx_data_length = ip_len_q;
   assign ip_tx_dst_ip_addr = dst_ip_q;

endmodule
